alu_seq: RTL and testbench

//  Parametrised multi-cycle successor to the combinational 16-bit ALU. It keeps the same 4-bit opcode map.

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle unsigned ALU behind valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge; MUL and DIV iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1111;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_GT  = 4'b1010;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             is_div;
  logic [CW-1:0]    cnt;

  logic             accept, start_iter, last;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] s_res;
  logic             s_carry, s_dbz;
  logic [WIDTH-1:0] mul_acc, div_rem, div_quo, fin;
  logic [WIDTH:0]   div_sh, div_tr;
  logic             qbit;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign start_iter = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));
  assign last       = (cnt == CW'(WIDTH - 1));

  // Single-cycle datapath, evaluated straight off the input operands.
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b};
    sub_w   = {1'b0, a} - {1'b0, b};
    s_res   = add_w[WIDTH-1:0];
    s_carry = add_w[WIDTH];
    s_dbz   = 1'b0;
    case (sel)
      OP_SUB: begin s_res = sub_w[WIDTH-1:0]; s_carry = sub_w[WIDTH]; end
      OP_MUL: begin s_res = '0; s_carry = 1'b0; end
      OP_DIV: begin s_res = '1; s_carry = 1'b0; s_dbz = (b == '0); end
      OP_SHL: begin s_res = (b >= WIDTH'(WIDTH)) ? '0 : (a << b); s_carry = 1'b0; end
      OP_SHR: begin s_res = (b >= WIDTH'(WIDTH)) ? '0 : (a >> b); s_carry = 1'b0; end
      OP_AND: begin s_res = a & b; s_carry = 1'b0; end
      OP_OR:  begin s_res = a | b; s_carry = 1'b0; end
      OP_GT:  begin s_res = {{(WIDTH-1){1'b0}}, (a > b)}; s_carry = 1'b0; end
      default: ;
    endcase
  end

  // Iteration step. MUL: opa is the shifting multiplicand, opb the shifting multiplier.
  // DIV: opa holds the remaining dividend bits and collects quotient bits from the bottom.
  always_comb begin
    mul_acc = acc + (opb[0] ? opa : '0);
    div_sh  = {acc, opa[WIDTH-1]};
    div_tr  = div_sh - {1'b0, opb};
    qbit    = ~div_tr[WIDTH];
    div_rem = qbit ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo = {opa[WIDTH-2:0], qbit};
    fin     = is_div ? div_quo : mul_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_iter ? BUSY : DONE;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      is_div      <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (start_iter) begin
            opa    <= a;
            opb    <= b;
            acc    <= '0;
            is_div <= (sel == OP_DIV);
            cnt    <= '0;
          end else begin
            result      <= s_res;
            carry       <= s_carry;
            zero        <= (s_res == '0);
            div_by_zero <= s_dbz;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc <= div_rem;
            opa <= div_quo;
          end else begin
            acc <= mul_acc;
            opa <= opa << 1;
            opb <= opb >> 1;
          end
          if (last) begin
            cnt         <= '0;
            result      <= fin;
            carry       <= 1'b0;
            zero        <= (fin == '0);
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes model results at accept, monitor pops on output handshake.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   sel;
  logic         carry, zero, div_by_zero;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    bit           c, z, dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  bit   seen = 0, post = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s);
    exp_t e;
    longint unsigned xa = x, yb = y, r, m = 64'd1 << W;
    e.c = 0; e.dbz = 0; e.lat = 1; e.acc_cyc = 0;
    case (s)
      4'b0011: begin r = (xa + m - yb) % m; e.c = (xa < yb); end
      4'b0101: begin r = (xa * yb) % m; e.lat = W + 1; end
      4'b0111: if (yb == 0) begin r = m - 1; e.dbz = 1; end
               else begin r = xa / yb; e.lat = W + 1; end
      4'b1101: r = (yb >= W) ? 0 : (xa << yb) % m;
      4'b1111: r = (yb >= W) ? 0 : (xa >> yb);
      4'b1001: r = xa & yb;
      4'b1011: r = xa | yb;
      4'b1010: r = (xa > yb) ? 1 : 0;
      default: begin r = (xa + yb) % m; e.c = ((xa + yb) >= m); end
    endcase
    e.res = r[W-1:0];
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] isel);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    a = ia; b = ib; sel = isel; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    e = model(ia, ib, isel);
    e.acc_cyc = cyc;
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) out_ready = 1'b1;
    else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: latency, held-stable outputs, in_ready low while a command is outstanding.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0; post = 0;
    end else begin
      if (post) begin
        chk("idle_after_hs_out_valid", out_valid, 0);
        chk("idle_after_hs_in_ready", in_ready, 1);
        post = 0;
      end
      if (sb.size() > 0 && !out_valid) chk("in_ready_while_busy", in_ready, 0);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0 result=%0h", result);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
            seen = 1;
          end
          chk("result", result, sb[0].res);
          chk("carry", carry, sb[0].c);
          chk("zero", zero, sb[0].z);
          chk("div_by_zero", div_by_zero, sb[0].dbz);
          chk("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0; post = 1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, div_by_zero}, 0);
    rst = 1'b0;

    issue(16'hFFFF, 16'd1, 4'b0001);
    issue(16'd300, 16'd300, 4'b0101);
    issue(16'd1000, 16'd7, 4'b0111);
    issue(16'd5, 16'd0, 4'b0111);
    issue(16'd1, 16'd16, 4'b1101);
    issue(16'h8000, 16'd15, 4'b1111);
    issue(16'd9, 16'd9, 4'b1010);
    issue(16'd2, 16'd3, 4'b0000);
    issue(16'hF0F0, 16'h0FF0, 4'b1001);
    issue(16'hF000, 16'h000F, 4'b1011);
    issue(16'hFFFF, 16'hFFFF, 4'b0101);
    issue(16'hFFFF, 16'd1, 4'b0111);
    drain();

    // Backpressure: result held for 5 cycles, then a single-cycle out_ready pulse.
    bp_mode = 2;
    @(posedge clk); #1 out_ready = 1'b0;
    issue(16'd3, 16'd5, 4'b0011);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    drain();
    bp_mode = 0;

    bp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 20)) : W'($urandom);
      issue(ra, rb, 4'($urandom_range(0, 15)));
    end
    drain();
    bp_mode = 0;

    // Reset in the middle of a DIV.
    issue(16'd1000, 16'd7, 4'b0111);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {carry, zero, div_by_zero}, 0);
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    issue(16'd1, 16'd1, 4'b0001);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
